// File: rtl/ce_scan_divider.sv
// ce_scan_divider: programmable clock-enable generator with a scan index.
// A cycle counter runs up to the active divisor, then emits a one-cycle
// enable pulse, flips a square-wave output and advances a scan index.
// New divisors are staged and applied only at a period boundary, so the
// counter never overruns the divisor it is counting against.
module ce_scan_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 20000,
  parameter int NDIG        = 4,
  parameter int IDXW        = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             load_i,
  output logic             ce_pulse_o,
  output logic             ce_toggle_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             idx_wrap_o
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NDIG - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_q;
  logic             pend_vld_q;
  logic             pulse_q;
  logic             toggle_q;
  logic [IDXW-1:0]  idx_q;
  logic             wrap_q;

  logic             tc_d;

  // Terminal count: last enabled cycle of the current period.
  always_comb begin
    tc_d = en_i && (cnt_q >= div_q);
  end

  // Counter, divisor staging and registered outputs; reset wins over all.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pulse_q    <= 1'b0;
      toggle_q   <= 1'b0;
      idx_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      // Off-boundary loads are only staged; the running period keeps its divisor.
      if (load_i && !tc_d) begin
        pend_q     <= div_i;
        pend_vld_q <= 1'b1;
      end

      if (tc_d) begin
        cnt_q    <= '0;
        pulse_q  <= 1'b1;
        toggle_q <= ~toggle_q;
        if (idx_q == IDX_LAST) begin
          idx_q  <= '0;
          wrap_q <= 1'b1;
        end else begin
          idx_q  <= idx_q + IDX_ONE;
          wrap_q <= 1'b0;
        end
        // A load landing on the boundary is newer than anything staged.
        if (load_i) begin
          div_q      <= div_i;
          pend_vld_q <= 1'b0;
        end else if (pend_vld_q) begin
          div_q      <= pend_q;
          pend_vld_q <= 1'b0;
        end
      end else begin
        if (en_i) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
        pulse_q <= 1'b0;
        wrap_q  <= 1'b0;
      end
    end
  end

  assign ce_pulse_o  = pulse_q;
  assign ce_toggle_o = toggle_q;
  assign idx_o       = idx_q;
  assign idx_wrap_o  = wrap_q;

endmodule

// File: tb/tb_ce_scan_divider.sv
// Bench for ce_scan_divider with DEFAULT_DIV=4, NDIG=4. Stimulus pushes the
// expected pulses (edge number, toggle, index, wrap) into a queue; a monitor
// pops one entry whenever the DUT raises its enable pulse.
module tb_ce_scan_divider;

  localparam int WIDTH = 16;
  localparam int IDXW  = 2;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic [WIDTH-1:0] div_i;
  logic             load_i;
  logic             ce_pulse_o;
  logic             ce_toggle_o;
  logic [IDXW-1:0]  idx_o;
  logic             idx_wrap_o;

  typedef struct {
    int             cyc;
    logic           tog;
    logic [IDXW-1:0] idx;
    logic           wrap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   r;

  ce_scan_divider #(
    .WIDTH(WIDTH), .DEFAULT_DIV(4), .NDIG(4), .IDXW(IDXW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .div_i(div_i), .load_i(load_i),
    .ce_pulse_o(ce_pulse_o), .ce_toggle_o(ce_toggle_o),
    .idx_o(idx_o), .idx_wrap_o(idx_wrap_o)
  );

  always #5 clk = ~clk;

  // Count rising edges so expectations can name the edge a pulse follows.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  // n-th pulse since reset: toggle = n odd, index = n mod 4, wrap when index returns to 0.
  task automatic push(input int c, input int n);
    exp_t e;
    e.cyc  = c;
    e.tog  = n[0];
    e.idx  = IDXW'(n % 4);
    e.wrap = ((n % 4) == 0);
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string name);
    chk(name, sb.size(), 0);
  endtask

  // One reset edge, check every output cleared, then release with EN=1.
  task automatic do_reset(output int rel);
    rst_i  = 1'b1;
    load_i = 1'b0;
    @(negedge clk);
    chk("rst_pulse",  ce_pulse_o,  0);
    chk("rst_toggle", ce_toggle_o, 0);
    chk("rst_idx",    idx_o,       0);
    chk("rst_wrap",   idx_wrap_o,  0);
    rst_i = 1'b0;
    en_i  = 1'b1;
    rel   = cyc;
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ce_pulse_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got pulse at edge %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_edge", cyc, mon_e.cyc);
        chk("pulse_tog_idx_wrap", {28'd0, ce_toggle_o, idx_o, idx_wrap_o},
            {28'd0, mon_e.tog, mon_e.idx, mon_e.wrap});
      end
    end
  end

  initial begin
    rst_i  = 1'b1;
    en_i   = 1'b0;
    load_i = 1'b0;
    div_i  = '0;
    repeat (3) @(negedge clk);

    // Basic period of 5 with index scan and wrap.
    do_reset(r);
    for (int n = 1; n <= 4; n++) push(r + 5 * n, n);
    wait_to(r + 21);
    drain("basic_drain");

    // Staged load of 2 mid-period: first period unchanged, then period 3.
    do_reset(r);
    push(r + 5, 1); push(r + 8, 2); push(r + 11, 3); push(r + 14, 4);
    wait_to(r + 1);
    load_i = 1'b1; div_i = 16'd2;
    @(negedge clk);
    load_i = 1'b0;
    wait_to(r + 15);
    drain("staged_drain");

    // Pending 6 overridden by a load of 1 on the terminal-count cycle.
    do_reset(r);
    push(r + 5, 1); push(r + 7, 2); push(r + 9, 3); push(r + 11, 4); push(r + 13, 5);
    wait_to(r + 1);
    load_i = 1'b1; div_i = 16'd6;
    @(negedge clk);
    load_i = 1'b0;
    wait_to(r + 4);
    load_i = 1'b1; div_i = 16'd1;
    @(negedge clk);
    load_i = 1'b0;
    wait_to(r + 14);
    drain("override_drain");

    // Freeze for 3 cycles at Q=2 in the second period: pulse slips by 3.
    do_reset(r);
    push(r + 5, 1); push(r + 13, 2); push(r + 18, 3);
    wait_to(r + 7);
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("freeze_pulse",  ce_pulse_o,  0);
      chk("freeze_toggle", ce_toggle_o, 1);
      chk("freeze_idx",    idx_o,       1);
    end
    en_i = 1'b1;
    wait_to(r + 19);
    drain("freeze_drain");

    // Divisor 0: pulse on every enabled cycle once it takes effect.
    do_reset(r);
    load_i = 1'b1; div_i = 16'd0;
    @(negedge clk);
    load_i = 1'b0;
    for (int n = 1; n <= 8; n++) push(r + 4 + n, n);
    wait_to(r + 12);
    en_i = 1'b0;
    wait_to(r + 13);
    drain("div0_drain");

    // Reset mid-period with a pending divisor: pending value discarded.
    do_reset(r);
    push(r + 5, 1);
    wait_to(r + 5);
    load_i = 1'b1; div_i = 16'd7;
    @(negedge clk);
    load_i = 1'b0;
    wait_to(r + 8);
    chk("pre_rst_toggle", ce_toggle_o, 1);
    chk("pre_rst_idx",    idx_o,       1);
    do_reset(r);
    push(r + 5, 1); push(r + 10, 2);
    wait_to(r + 11);
    drain("rst_pending_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
